// File: rtl/mii_frame_collector.sv
// Receive-side frame assembler: collects START..TERM bytes from 64b/8-lane MII words into a flat buffer.
// Optional statistics counters enabled by defining MII_COLLECT_STATS_EN.
module mii_frame_collector #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CTRL_WIDTH     = 8,
    parameter int unsigned MAX_FRAME_SIZE = 1518,
    parameter logic [7:0]  IDLE_CODE      = 8'h07,
    parameter logic [7:0]  START_CODE     = 8'hFB,
    parameter logic [7:0]  TERM_CODE      = 8'hFD
) (
    input  logic                                 clk,
    input  logic                                 i_rst_n,
    input  logic [DATA_WIDTH-1:0]                i_rx_data,
    input  logic [CTRL_WIDTH-1:0]                i_rx_ctrl,
    input  logic                                 i_rx_valid,
    output logic [(MAX_FRAME_SIZE+11)*8-1:0]     o_frame_data,
    output logic [10:0]                          o_frame_len,
    output logic                                 o_frame_valid,
    output logic                                 o_ctrl_error,
    output logic                                 o_overflow_error
`ifdef MII_COLLECT_STATS_EN
    ,
    output logic [31:0]                          o_frame_cnt,
    output logic [31:0]                          o_drop_cnt
`endif
);

    localparam int unsigned BUF_BYTES = MAX_FRAME_SIZE + 11;
    localparam int unsigned LANES     = CTRL_WIDTH;
    localparam logic [11:0] BUF_W     = 12'(BUF_BYTES);
    // A degenerate code set (colliding characters) disables framing entirely.
    localparam bit CODES_DISTINCT = (IDLE_CODE != START_CODE) && (IDLE_CODE != TERM_CODE)
                                    && (START_CODE != TERM_CODE);

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t                   state_q, state_d;
    logic [11:0]              count_q;
    logic [BUF_BYTES*8-1:0]   buf_q;
    logic [10:0]              len_q;
    logic                     done_pend, ctrl_pend, ovf_pend;

    logic                     is_start, accept, clear_buf;
    logic [11:0]              wr_base, frame_len;
    logic [LANES-1:0]         lane_ctrl, lane_mask;
    logic                     term_found, bad_found;
    logic [2:0]               term_lane;
    logic                     ev_ctrl, ev_done, ev_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state, control-lane scan and word disposition
    always_comb begin
        state_d    = state_q;
        is_start   = CODES_DISTINCT && i_rx_ctrl[0] && (i_rx_data[7:0] == START_CODE);
        accept     = i_rx_valid && ((state_q == S_COLLECT) || ((state_q == S_IDLE) && is_start));
        clear_buf  = accept && (state_q == S_IDLE);
        wr_base    = (state_q == S_IDLE) ? 12'd0 : count_q;
        // Lane 0 of the START word is the START character itself, not a frame-level control.
        lane_ctrl  = i_rx_ctrl & ((state_q == S_IDLE) ? ~LANES'(1) : '1);
        term_found = 1'b0;
        bad_found  = 1'b0;
        term_lane  = 3'd0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_ctrl[k] && !term_found && !bad_found) begin
                if (i_rx_data[8*k +: 8] == TERM_CODE) begin
                    term_found = 1'b1;
                    term_lane  = 3'(k);
                end else begin
                    bad_found = 1'b1;
                end
            end
        end
        frame_len = wr_base + 12'(term_lane) + 12'd1;
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mask[k] = accept && !bad_found && (!term_found || (3'(k) <= term_lane))
                           && ((wr_base + 12'(k)) < BUF_W);
        end
        ev_ctrl = accept && bad_found;
        ev_done = accept && !bad_found && term_found && (frame_len <= BUF_W);
        ev_ovf  = accept && !bad_found &&
                  (term_found ? (frame_len > BUF_W) : ((wr_base + 12'd8) >= BUF_W));
        if (accept) state_d = (ev_ctrl || ev_done || ev_ovf) ? S_IDLE : S_COLLECT;
    end

    // Working buffer, byte count and registered result/strobes
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            count_q          <= '0;
            buf_q            <= '0;
            len_q            <= '0;
            done_pend        <= 1'b0;
            ctrl_pend        <= 1'b0;
            ovf_pend         <= 1'b0;
            o_frame_data     <= '0;
            o_frame_len      <= '0;
            o_frame_valid    <= 1'b0;
            o_ctrl_error     <= 1'b0;
            o_overflow_error <= 1'b0;
        end else begin
            if (accept) count_q <= (state_d == S_COLLECT) ? (wr_base + 12'd8) : 12'd0;
            if (clear_buf) buf_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                if (lane_mask[k]) buf_q[{wr_base + 12'(k), 3'b000} +: 8] <= i_rx_data[8*k +: 8];
            end
            if (ev_done) len_q <= frame_len[10:0];
            done_pend        <= ev_done;
            ctrl_pend        <= ev_ctrl;
            ovf_pend         <= ev_ovf;
            o_frame_valid    <= done_pend;
            o_ctrl_error     <= ctrl_pend;
            o_overflow_error <= ovf_pend;
            // Copy sees the buffer before any same-cycle START clears it.
            if (done_pend) begin
                o_frame_data <= buf_q;
                o_frame_len  <= len_q;
            end
        end
    end

`ifdef MII_COLLECT_STATS_EN
    // Saturating frame/drop counters
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            o_frame_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            if (done_pend && (o_frame_cnt != '1)) o_frame_cnt <= o_frame_cnt + 32'd1;
            if ((ctrl_pend || ovf_pend) && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mii_frame_collector.sv
// Directed self-checking bench for mii_frame_collector: frames, errors, overflow, stalls, reset.
module tb_mii_frame_collector;

    localparam int unsigned BUF_B  = 1529;
    localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;

    logic                 clk;
    logic                 i_rst_n;
    logic [63:0]          i_rx_data;
    logic [7:0]           i_rx_ctrl;
    logic                 i_rx_valid;
    logic [BUF_B*8-1:0]   o_frame_data;
    logic [10:0]          o_frame_len;
    logic                 o_frame_valid;
    logic                 o_ctrl_error;
    logic                 o_overflow_error;
`ifdef MII_COLLECT_STATS_EN
    logic [31:0]          frame_cnt;
    logic [31:0]          drop_cnt;
`endif

    mii_frame_collector dut (
        .clk              (clk),
        .i_rst_n          (i_rst_n),
        .i_rx_data        (i_rx_data),
        .i_rx_ctrl        (i_rx_ctrl),
        .i_rx_valid       (i_rx_valid),
        .o_frame_data     (o_frame_data),
        .o_frame_len      (o_frame_len),
        .o_frame_valid    (o_frame_valid),
        .o_ctrl_error     (o_ctrl_error),
        .o_overflow_error (o_overflow_error)
`ifdef MII_COLLECT_STATS_EN
        ,
        .o_frame_cnt      (frame_cnt),
        .o_drop_cnt       (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_start = 0;
    int t_valid = 0;
    int t_ctrl  = 0;
    int t_ovf   = 0;
    int n_valid = 0;
    int n_ctrl  = 0;
    int n_ovf   = 0;
    logic [BUF_B*8-1:0] got_data_q [$];
    logic [10:0]        got_len_q  [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (o_frame_valid) begin
            n_valid <= n_valid + 1;
            t_valid <= cyc;
            got_data_q.push_back(o_frame_data);
            got_len_q.push_back(o_frame_len);
        end
        if (o_ctrl_error) begin
            n_ctrl <= n_ctrl + 1;
            t_ctrl <= cyc;
        end
        if (o_overflow_error) begin
            n_ovf <= n_ovf + 1;
            t_ovf <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] c, input logic v);
        i_rx_data  = d;
        i_rx_ctrl  = c;
        i_rx_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(IDLE_W, 8'hFF, 1'b1);
    endtask

    // START word, n data words (byte p = seed+p), TERM in lane 0 of word n+1; builds expected buffer.
    task automatic send_words(input logic [7:0] seed, input int n, input int stall_at,
                              input int stall_len, input int bad_at, input int rst_at,
                              output logic [BUF_B*8-1:0] exp, output int exp_len);
        logic [63:0] w;
        logic [7:0]  c;
        logic [7:0]  b;
        int          p;
        exp = '0;
        for (int i = 0; i <= n + 1; i++) begin
            if (i == stall_at) repeat (stall_len) step(64'hFDFD_FDFD_FDFD_FDFB, 8'hFF, 1'b0);
            c = (i == 0) ? 8'h01 : (i == n + 1) ? 8'hFF : 8'h00;
            for (int k = 0; k < 8; k++) begin
                p = 8 * i + k;
                if (i == 0)          b = (k == 0) ? 8'hFB : (k == 7) ? 8'hD5 : 8'h55;
                else if (i == n + 1) b = (k == 0) ? 8'hFD : 8'h07;
                else                 b = seed + 8'(p);
                if (i == bad_at && k == 3) b = 8'hFE;
                w[8*k +: 8] = b;
                if ((i <= n || k == 0) && p < BUF_B) exp[8*p +: 8] = b;
            end
            if (i == bad_at) c = 8'h08;
            i_rst_n = (i == rst_at) ? 1'b0 : 1'b1;
            step(w, c, 1'b1);
            if (i == 0) t_start = cyc;
        end
        i_rst_n = 1'b1;
        exp_len = 8 * n + 9;
    endtask

    task automatic check_frame(input string tag, input logic [BUF_B*8-1:0] exp, input int exp_len);
        logic [BUF_B*8-1:0] d;
        logic [10:0]        l;
        check({tag, " present"}, 32'(got_len_q.size() > 0), 32'd1);
        if (got_len_q.size() > 0) begin
            d = got_data_q.pop_front();
            l = got_len_q.pop_front();
            check({tag, " len"}, 32'(l), 32'(exp_len));
            check({tag, " data"}, 32'(d == exp), 32'd1);
            check({tag, " byte0"}, 32'(d[7:0]), 32'hFB);
            check({tag, " term"}, 32'(d[8*(exp_len-1) +: 8]), 32'hFD);
            if (exp_len < BUF_B) check({tag, " tail"}, 32'(d[8*exp_len +: 8]), 32'h0);
        end
    endtask

    logic [BUF_B*8-1:0] exp_a, exp_b, exp_t1;
    int                 len_a, len_b;

    initial begin
        i_rst_n = 1'b0;
        idle(2);
        check("rst valid", 32'(o_frame_valid), 0);
        check("rst len", 32'(o_frame_len), 0);
        check("rst data", 32'(o_frame_data == '0), 1);
        check("rst ctrl_err", 32'(o_ctrl_error), 0);
        check("rst ovf_err", 32'(o_overflow_error), 0);
        i_rst_n = 1'b1;
        idle(2);

        // Minimum frame: 73 bytes, valid 10 cycles after START edge, one cycle wide
        send_words(8'h10, 8, -1, 0, -1, -1, exp_t1, len_a);
        check("t1 valid early", 32'(o_frame_valid), 0);
        idle(1);
        check("t1 valid", 32'(o_frame_valid), 1);
        idle(1);
        check("t1 valid width", 32'(o_frame_valid), 0);
        check_frame("t1", exp_t1, len_a);
        check("t1 latency", 32'(t_valid - t_start), 32'd10);
        check("t1 len73", 32'(len_a), 32'd73);

        // Idles only: nothing happens, outputs hold
        idle(100);
        check("t2 n_valid", 32'(n_valid), 1);
        check("t2 n_err", 32'(n_ctrl + n_ovf), 0);
        check("t2 len hold", 32'(o_frame_len), 32'd73);
        check("t2 data hold", 32'(o_frame_data == exp_t1), 1);

        // Bad control char at word 4 lane 3; rest of frame (incl. stray TERM) ignored
        send_words(8'h20, 8, -1, 0, 4, -1, exp_a, len_a);
        idle(3);
        check("t3 n_ctrl", 32'(n_ctrl), 1);
        check("t3 ctrl latency", 32'(t_ctrl - t_start), 32'd5);
        check("t3 no valid", 32'(n_valid), 1);
        check("t3 data hold", 32'(o_frame_data == exp_t1), 1);
        send_words(8'h30, 8, -1, 0, -1, -1, exp_a, len_a);
        idle(3);
        check_frame("t3 good", exp_a, len_a);

        // No TERM: overflow on the word at offset 1528 (data word 191)
        send_words(8'h40, 200, -1, 0, -1, -1, exp_a, len_a);
        idle(3);
        check("t4 n_ovf", 32'(n_ovf), 1);
        check("t4 ovf latency", 32'(t_ovf - t_start), 32'd192);
        check("t4 no valid", 32'(n_valid), 2);
        send_words(8'h41, 8, -1, 0, -1, -1, exp_a, len_a);
        idle(3);
        check_frame("t4 good", exp_a, len_a);

        // Largest frame: TERM at byte 1528 fills buffer exactly
        send_words(8'h42, 190, -1, 0, -1, -1, exp_a, len_a);
        idle(3);
        check_frame("t4 full", exp_a, len_a);
        check("t4 full n_ovf", 32'(n_ovf), 1);

        // Stall 3 cycles before word 5: same content, valid 3 cycles later
        send_words(8'h10, 8, 5, 3, -1, -1, exp_a, len_a);
        idle(3);
        check_frame("t5", exp_a, len_a);
        check("t5 same as t1", 32'(exp_a == exp_t1), 1);
        check("t5 latency", 32'(t_valid - t_start), 32'd13);
`ifdef MII_COLLECT_STATS_EN
        check("stats frames", frame_cnt, 32'd5);
        check("stats drops", drop_cnt, 32'd2);
`endif

        // Reset at word 5 discards the frame, clears outputs, no strobes follow
        send_words(8'h50, 8, -1, 0, -1, 5, exp_a, len_a);
        idle(3);
        check("t6 valid", 32'(o_frame_valid), 0);
        check("t6 len", 32'(o_frame_len), 0);
        check("t6 data", 32'(o_frame_data == '0), 1);
        check("t6 n_valid", 32'(n_valid), 5);
        check("t6 n_err", 32'(n_ctrl + n_ovf), 2);
`ifdef MII_COLLECT_STATS_EN
        check("t6 stats frames", frame_cnt, 32'd0);
        check("t6 stats drops", drop_cnt, 32'd0);
`endif

        // Back-to-back: START directly after TERM word
        send_words(8'h60, 8, -1, 0, -1, -1, exp_a, len_a);
        send_words(8'h70, 9, -1, 0, -1, -1, exp_b, len_b);
        idle(3);
        check("b2b n_valid", 32'(n_valid), 7);
        check_frame("b2b a", exp_a, len_a);
        check_frame("b2b b", exp_b, len_b);
        check("b2b len81", 32'(len_b), 32'd81);
`ifdef MII_COLLECT_STATS_EN
        check("b2b stats frames", frame_cnt, 32'd2);
`endif
        check("queue empty", 32'(got_len_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
